// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [63:0] PC_INCR   = 64'd4;
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  // Redirect targets are always word aligned; the low two bits are dropped.
  function automatic logic [63:0] align_target(input logic [63:0] target);
    return target & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_incrementer.sv
// 64-bit sequential PC adder (+4, wraps modulo 2^64).
module fetch_unit_pc_incrementer
  import fetch_unit_pkg::*;
(
  input  logic [63:0] pc,
  output logic [63:0] pc_next
);

  assign pc_next = pc + PC_INCR;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential imem requests, handles downstream
// stall via a one-entry hold buffer and absorbs branch redirects.
// Optional macro FETCH_BUBBLE_NOP_EN: invalid/discarded slots present a NOP
// with the current pc instead of holding the previous instruction.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [63:0] branchTarget,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_Fetch,
  output logic [63:0] programCounter_Fetch,
  output logic        fetchValid
);

  fetch_state_e state;
  logic [63:0]  pc;
  logic [63:0]  pc_plus4;
  logic         redirect_pending;
  logic [63:0]  redirect_target;
  logic [31:0]  hold_instr;
  logic [63:0]  hold_pc;

  fetch_unit_pc_incrementer u_pc_incrementer (
    .pc      (pc),
    .pc_next (pc_plus4)
  );

  // The request address is the pc register itself, so it cannot move while
  // a request is outstanding: pc only changes on acceptance or in HOLD.
  assign imem_addr = pc;

`ifdef FETCH_BUBBLE_NOP_EN
  logic bubble;

  // Flags every cycle whose outcome is fetchValid going low.
  always_comb begin
    bubble = 1'b0;
    if (state == REQ) begin
      bubble = imem_ready ? (branchTaken || redirect_pending) : !stall;
    end else if (state == HOLD) begin
      bubble = branchTaken;
    end
  end
`endif

  // Fetch FSM with registered pc, request and fetch-stage outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                <= IDLE;
      pc                   <= RESET_PC;
      imem_req             <= 1'b0;
      fetchValid           <= 1'b0;
      instruction_Fetch    <= 32'h0;
      programCounter_Fetch <= 64'h0;
      redirect_pending     <= 1'b0;
      redirect_target      <= 64'h0;
      hold_instr           <= 32'h0;
      hold_pc              <= 64'h0;
    end else begin
`ifdef FETCH_BUBBLE_NOP_EN
      if (bubble) begin
        instruction_Fetch    <= NOP_INSTR;
        programCounter_Fetch <= pc;
      end
`endif
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            if (branchTaken || redirect_pending) begin
              // Wrong-path response: drop it; a fresh branch beats a stored one.
              pc               <= branchTaken ? align_target(branchTarget) : redirect_target;
              redirect_pending <= 1'b0;
              fetchValid       <= 1'b0;
            end else if (stall) begin
              hold_instr <= imem_rdata;
              hold_pc    <= pc;
              pc         <= pc_plus4;
              state      <= HOLD;
              imem_req   <= 1'b0;
            end else begin
              instruction_Fetch    <= imem_rdata;
              programCounter_Fetch <= pc;
              fetchValid           <= 1'b1;
              pc                   <= pc_plus4;
            end
          end else begin
            // Request stays up until accepted; redirect is deferred.
            if (branchTaken) begin
              redirect_pending <= 1'b1;
              redirect_target  <= align_target(branchTarget);
            end
            if (!stall) begin
              fetchValid <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (branchTaken) begin
            pc         <= align_target(branchTarget);
            fetchValid <= 1'b0;
            hold_instr <= 32'h0;
            hold_pc    <= 64'h0;
            state      <= REQ;
            imem_req   <= 1'b1;
          end else if (!stall) begin
            instruction_Fetch    <= hold_instr;
            programCounter_Fetch <= hold_pc;
            fetchValid           <= 1'b1;
            state                <= REQ;
            imem_req             <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetched
// (pc, instruction) pairs; a monitor pops one per consumed fetch slot.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [63:0] branchTarget;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_Fetch;
  logic [63:0] programCounter_Fetch;
  logic        fetchValid;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .stall                (stall),
    .branchTaken          (branchTaken),
    .branchTarget         (branchTarget),
    .imem_req             (imem_req),
    .imem_addr            (imem_addr),
    .imem_ready           (imem_ready),
    .imem_rdata           (imem_rdata),
    .instruction_Fetch    (instruction_Fetch),
    .programCounter_Fetch (programCounter_Fetch),
    .fetchValid           (fetchValid)
  );

  // Instruction memory model: word content derived from its address.
  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic push(input logic [63:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem(a);
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A fetch slot is consumed at the next edge when valid and not stalled.
  always @(negedge clk) begin
    if (reset === 1'b1 && fetchValid === 1'b1 && stall === 1'b0) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got pc %h, expected no fetch", programCounter_Fetch);
      end else begin
        mon_e = q.pop_front();
        if (programCounter_Fetch !== mon_e.pc || instruction_Fetch !== mon_e.instr) begin
          fails++;
          $display("FAIL sb_fetch: got pc %h instr %h, expected pc %h instr %h",
                   programCounter_Fetch, instruction_Fetch, mon_e.pc, mon_e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b0;
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = 64'h0;
    imem_ready   = 1'b1;
    repeat (2) tick();
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(fetchValid), 64'd0);
    check("rst_instr", 64'(instruction_Fetch), 64'h0);
    check("rst_pcf", programCounter_Fetch, 64'h0);
    check("rst_addr", imem_addr, 64'h0);

    // Sequential fetch from reset.
    reset = 1'b1;
    push(64'h0); push(64'h4); push(64'h8); push(64'hC);
    tick();
    check("seq_req", 64'(imem_req), 64'd1);
    check("seq_addr0", imem_addr, 64'h0);
    tick();
    check("seq_addr4", imem_addr, 64'h4);
    check("seq_valid", 64'(fetchValid), 64'd1);
    check("seq_pcf0", programCounter_Fetch, 64'h0);
    tick();
    check("seq_pcf4", programCounter_Fetch, 64'h4);
    check("seq_addr8", imem_addr, 64'h8);
    tick();
    check("seq_pcf8", programCounter_Fetch, 64'h8);
    tick();
    check("seq_addr10", imem_addr, 64'h10);

    // Memory not ready for three cycles.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_req", 64'(imem_req), 64'd1);
      check("wait_addr", imem_addr, 64'h10);
      check("wait_valid", 64'(fetchValid), 64'd0);
    end
    imem_ready = 1'b1;
    push(64'h10);
    tick();
    check("wait_pcf", programCounter_Fetch, 64'h10);
    check("wait_addr14", imem_addr, 64'h14);

    // Stall coincident with acceptance of 0x20.
    push(64'h14); push(64'h18); push(64'h1C);
    repeat (3) tick();
    check("pre_stall_addr", imem_addr, 64'h20);
    stall = 1'b1;
    tick();
    check("hold_req", 64'(imem_req), 64'd0);
    check("hold_pcf", programCounter_Fetch, 64'h1C);
    check("hold_valid", 64'(fetchValid), 64'd1);
    tick();
    check("hold_pcf2", programCounter_Fetch, 64'h1C);
    push(64'h20);
    stall = 1'b0;
    tick();
    check("unhold_pcf", programCounter_Fetch, 64'h20);
    check("unhold_req", 64'(imem_req), 64'd1);
    check("unhold_addr", imem_addr, 64'h24);

    // Redirects while waiting on 0x30; second target wins, low bits dropped.
    push(64'h24); push(64'h28); push(64'h2C);
    repeat (3) tick();
    check("pre_br_addr", imem_addr, 64'h30);
    imem_ready = 1'b0;
    tick();
    branchTaken  = 1'b1;
    branchTarget = 64'h200;
    tick();
    branchTarget = 64'h403;
    tick();
    branchTaken = 1'b0;
    check("br_wait_addr", imem_addr, 64'h30);
    check("br_wait_req", 64'(imem_req), 64'd1);
    imem_ready = 1'b1;
    tick();
    check("br_disc_valid", 64'(fetchValid), 64'd0);
    check("br_new_addr", imem_addr, 64'h400);
    push(64'h400);
    tick();
    check("br_pcf400", programCounter_Fetch, 64'h400);

    // Redirect on acceptance, then PC wrap.
    branchTaken  = 1'b1;
    branchTarget = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    branchTaken = 1'b0;
    check("br_rdy_valid", 64'(fetchValid), 64'd0);
    check("br_rdy_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    push(64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    check("wrap_addr_fffc", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_addr0", imem_addr, 64'h0);
    check("wrap_pcf", programCounter_Fetch, 64'hFFFF_FFFF_FFFF_FFFC);

    // Branch while in HOLD discards the buffered instruction.
    stall = 1'b1;
    tick();
    check("hold2_req", 64'(imem_req), 64'd0);
    check("hold2_valid", 64'(fetchValid), 64'd1);
    branchTaken  = 1'b1;
    branchTarget = 64'h800;
    tick();
    branchTaken = 1'b0;
    check("hbr_valid", 64'(fetchValid), 64'd0);
    check("hbr_req", 64'(imem_req), 64'd1);
    check("hbr_addr", imem_addr, 64'h800);

    // Request held under stall, then reset mid-request.
    imem_ready = 1'b0;
    tick();
    check("stall_wait_req", 64'(imem_req), 64'd1);
    check("stall_wait_addr", imem_addr, 64'h800);
    reset = 1'b0;
    tick();
    check("mid_rst_req", 64'(imem_req), 64'd0);
    check("mid_rst_valid", 64'(fetchValid), 64'd0);
    check("mid_rst_addr", imem_addr, 64'h0);
    check("mid_rst_pcf", programCounter_Fetch, 64'h0);
    reset      = 1'b1;
    stall      = 1'b0;
    imem_ready = 1'b1;
    push(64'h0);
    tick();
    check("restart_req", 64'(imem_req), 64'd1);
    tick();
    check("restart_pcf", programCounter_Fetch, 64'h0);
    check("restart_valid", 64'(fetchValid), 64'd1);
    imem_ready = 1'b0;
    repeat (2) tick();

    check("sb_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
